vmem_arbiter: RTL

Two-port arbiter and burst sequencer for the vector data memory (WRDataMemory) of the vector CPU. It shares the single memory port between two requesters, R0 (vector load/store unit) and R1 (loader/DMA), using round-robin arbitration. Each granted transaction is a burst of 1..2^LENW vector beats, one full-width beat per cycle. The block drives the memory's WE/A/WD and registers RD back to the owning requester.

---
 rtl/vmem_arbiter_if.sv | 30 +++
 rtl/vmem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vmem_arbiter_if.sv
// Requester channel of the vector data memory arbiter: one instance per requester.
// Bus beats are the only payload; the arbiter owns the memory port itself.
interface vmem_arbiter_if #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int LENW  = 4
);
    // Handshake: req rises with wr/addr/len stable and stays high until done pulses;
    // wd holds the current write beat until wd_ack, rd is new only while rd_valid.
    logic                  req;
    logic                  wr;
    logic [AW-1:0]         addr;
    logic [LENW-1:0]       len;
    logic [LANES*DW-1:0]   wd;
    logic                  wd_ack;
    logic [LANES*DW-1:0]   rd;
    logic                  rd_valid;
    logic                  done;

    modport master (
        output req, wr, addr, len, wd,
        input  wd_ack, rd, rd_valid, done
    );

    modport slave (
        input  req, wr, addr, len, wd,
        output wd_ack, rd, rd_valid, done
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one vector data memory port
// between two requesters; bursts of len+1 full-width beats, one per cycle.
module vmem_arbiter #(
    parameter int LANES  = 16,
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int STRIDE = 16,
    parameter int LENW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    vmem_arbiter_if.slave       r0,
    vmem_arbiter_if.slave       r1,
    output logic                mem_we,
    output logic [AW-1:0]       mem_a,
    output logic [LANES*DW-1:0] mem_wd,
    input  logic [LANES*DW-1:0] mem_rd,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    localparam int W = LANES * DW;
    localparam logic [AW-1:0] STEP = AW'(STRIDE);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic            wr_q;
    logic [LENW-1:0] beats_left;
    logic [AW-1:0]   cur_addr;
    logic            mem_we_q;
    logic [1:0]      wd_ack_q;
    logic [1:0]      rd_valid_q;
    logic [1:0]      done_q;
    logic [W-1:0]    rd0_q;
    logic [W-1:0]    rd1_q;

    logic            grant_any;
    logic            grant_sel;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [LENW-1:0] sel_len;

    // With both requesting, the one not granted last time wins.
    always_comb begin
        grant_any = r0.req | r1.req;
        grant_sel = 1'b0;
        if (r0.req && r1.req) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = r1.req;
        end
        sel_wr   = grant_sel ? r1.wr   : r0.wr;
        sel_addr = grant_sel ? r1.addr : r0.addr;
        sel_len  = grant_sel ? r1.len  : r0.len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wr_q       <= 1'b0;
            beats_left <= '0;
            cur_addr   <= '0;
            mem_we_q   <= 1'b0;
            wd_ack_q   <= 2'b00;
            rd_valid_q <= 2'b00;
            done_q     <= 2'b00;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            rd_valid_q <= 2'b00;
            done_q     <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state      <= XFER;
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        wr_q       <= sel_wr;
                        cur_addr   <= sel_addr;
                        beats_left <= sel_len;
                        mem_we_q   <= sel_wr;
                        wd_ack_q   <= sel_wr ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
                    end
                end
                XFER: begin
                    cur_addr   <= cur_addr + STEP;
                    beats_left <= beats_left - 1'b1;
                    if (!wr_q) begin
                        if (owner) rd1_q <= mem_rd;
                        else       rd0_q <= mem_rd;
                        rd_valid_q[owner] <= 1'b1;
                    end
                    // Last beat: address returns to 0 so DONE and IDLE present a quiet bus.
                    if (beats_left == '0) begin
                        state         <= DONE;
                        cur_addr      <= '0;
                        mem_we_q      <= 1'b0;
                        wd_ack_q      <= 2'b00;
                        done_q[owner] <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_a     = cur_addr;
    assign mem_wd    = mem_we_q ? (owner ? r1.wd : r0.wd) : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign r0.wd_ack   = wd_ack_q[0];
    assign r1.wd_ack   = wd_ack_q[1];
    assign r0.rd_valid = rd_valid_q[0];
    assign r1.rd_valid = rd_valid_q[1];
    assign r0.done     = done_q[0];
    assign r1.done     = done_q[1];
    assign r0.rd       = rd0_q;
    assign r1.rd       = rd1_q;
endmodule
